// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the switch/button ALU front-end controller.
//  - state_e : sequencer FSM states
//  - BTN_*   : button index of each load register within i_btn / o_loaded
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EXEC    = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

endpackage

// File: rtl/alu_input_sequencer_btn_debounce.sv
// btn_debounce: conditions one raw asynchronous push button.
//  - 2-FF synchroniser
//  - debounce: the debounced level follows the synced level only after
//    DEB_CYC consecutive samples that differ from the current debounced level
//  - o_press: one-cycle pulse on a 0->1 transition of the debounced level
// Ports:
//  clock    in  system clock, rising edge
//  i_reset  in  asynchronous reset, active-low
//  i_btn    in  raw button, active-high
//  o_press  out one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter and press edge. A sample equal to the debounced level
  // means the synced input changed back, so the run of differing samples
  // restarts from zero.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= {CNT_W{1'b0}};
        r_level <= r_sync2;
        r_press <= r_sync2;  // only the rising transition is an event
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: front-end controller for the switch/button ALU.
// Debounces three buttons, loads operand A / operand B / opcode from the
// switches, fires one ALU start pulse once all three are loaded, waits the
// ALU latency and captures the result into the LED register.
// Ports:
//  clock           in   system clock, rising edge
//  i_reset         in   asynchronous reset, active-low
//  i_sw            in   raw switches, sampled on a load press
//  i_btn           in   raw buttons {OP,B,A}, active-high
//  i_alu_result    in   ALU result bus
//  o_data_a/b/op   out  operand and opcode registers
//  o_alu_start     out  one-cycle ALU start pulse (first EXEC cycle)
//  o_led           out  captured result
//  o_result_valid  out  o_led belongs to the current operand set
//  o_loaded        out  load mask {OP,B,A}
//  o_busy          out  high in EXEC; presses are dropped
module alu_input_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NB_SW   = 6,
  parameter int NB_BTN  = 3,
  parameter int DEB_CYC = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_SW-1:0]  i_sw,
  input  logic [NB_BTN-1:0] i_btn,
  input  logic [NB_SW-1:0]  i_alu_result,
  output logic [NB_SW-1:0]  o_data_a,
  output logic [NB_SW-1:0]  o_data_b,
  output logic [NB_SW-1:0]  o_op,
  output logic              o_alu_start,
  output logic [NB_SW-1:0]  o_led,
  output logic              o_result_valid,
  output logic [NB_BTN-1:0] o_loaded,
  output logic              o_busy
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  logic [NB_BTN-1:0] w_press;
  state_e            r_state;
  state_e            w_next;
  logic              w_load_en;
  logic              w_capture;
  logic              w_exec_entry;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [NB_SW-1:0]  r_data_a;
  logic [NB_SW-1:0]  r_data_b;
  logic [NB_SW-1:0]  r_op;
  logic [NB_SW-1:0]  r_led;
  logic              r_alu_start;
  logic              r_result_valid;
  logic [NB_BTN-1:0] r_loaded;
  logic              r_busy;

  genvar g;
  generate
    for (g = 0; g < NB_BTN; g++) begin : g_btn
      btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clock   (clock),
        .i_reset (i_reset),
        .i_btn   (i_btn[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus load-enable and capture strobes.
  always_comb begin
    w_next    = r_state;
    w_load_en = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_en = 1'b1;
        if (|w_press) begin
          w_next = COLLECT;
        end else begin
          w_next = IDLE;
        end
      end
      COLLECT: begin
        w_load_en = 1'b1;
        if (&r_loaded) begin
          w_next = EXEC;
        end else begin
          w_next = COLLECT;
        end
      end
      EXEC: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end else begin
          w_next = EXEC;
        end
      end
      HOLD: begin
        w_load_en = 1'b1;
        if (|w_press) begin
          w_next = COLLECT;
        end else begin
          w_next = HOLD;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_exec_entry = (r_state == COLLECT) && (w_next == EXEC);

  // Operand/opcode registers; each loads only on its own press.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_data_a <= {NB_SW{1'b0}};
      r_data_b <= {NB_SW{1'b0}};
      r_op     <= {NB_SW{1'b0}};
    end else begin
      if (w_load_en && w_press[BTN_A]) begin
        r_data_a <= i_sw;
      end
      if (w_load_en && w_press[BTN_B]) begin
        r_data_b <= i_sw;
      end
      if (w_load_en && w_press[BTN_OP]) begin
        r_op <= i_sw;
      end
    end
  end

  // Load mask; clearing on EXEC entry wins over a coincident press.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_loaded <= {NB_BTN{1'b0}};
    end else if (w_exec_entry) begin
      r_loaded <= {NB_BTN{1'b0}};
    end else if (w_load_en) begin
      r_loaded <= r_loaded | w_press;
    end
  end

  // Start pulse, busy flag and ALU latency counter.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_alu_start <= 1'b0;
      r_busy      <= 1'b0;
      r_lat_cnt   <= {LAT_W{1'b0}};
    end else begin
      r_alu_start <= w_exec_entry;
      r_busy      <= (w_next == EXEC);
      if (r_state == EXEC) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end else begin
        r_lat_cnt <= {LAT_W{1'b0}};
      end
    end
  end

  // Result capture; the LED value survives a new press, only the valid flag drops.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_led          <= {NB_SW{1'b0}};
      r_result_valid <= 1'b0;
    end else if (w_capture) begin
      r_led          <= i_alu_result;
      r_result_valid <= 1'b1;
    end else if ((r_state == HOLD) && (|w_press)) begin
      r_result_valid <= 1'b0;
    end
  end

  assign o_data_a       = r_data_a;
  assign o_data_b       = r_data_b;
  assign o_op           = r_op;
  assign o_alu_start    = r_alu_start;
  assign o_led          = r_led;
  assign o_result_valid = r_result_valid;
  assign o_loaded       = r_loaded;
  assign o_busy         = r_busy;

endmodule
